// File: rtl/entropy_shock_pkg.sv
// Shared types and helpers for the entropy shock monitor.
// Defines the per-channel FSM state encoding and the absolute-difference helper.
package entropy_shock_pkg;

    localparam int unsigned StateW   = 2;
    // Widest sample the helper function accepts.
    localparam int unsigned MaxWidth = 32;

    typedef enum logic [StateW-1:0] {
        StPrime,
        StArmed,
        StPending,
        StShock
    } shock_state_e;

    function automatic logic [MaxWidth:0] abs_diff(input logic [MaxWidth-1:0] a,
                                                   input logic [MaxWidth-1:0] b);
        return (a >= b) ? {1'b0, a - b} : {1'b0, b - a};
    endfunction

endpackage

// File: rtl/entropy_shock_monitor_if.sv
// Sample/threshold inputs and shock report outputs of the entropy shock monitor.
// The master side drives samples; the slave side is the monitor itself.
interface entropy_shock_monitor_if #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned CNT_W    = 16
) ();
    localparam int unsigned ChanW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                      sample_valid;
    logic [CHANNELS*WIDTH-1:0] sample_data;
    logic [WIDTH-1:0]          thresh_hi;
    logic [WIDTH-1:0]          thresh_lo;
    logic                      clear;
    logic [CHANNELS-1:0]       shock_flags;
    logic                      shock_any;
    logic [ChanW-1:0]          shock_chan;
    logic                      event_pulse;
    logic [CNT_W-1:0]          event_count;

    modport master (
        output sample_valid, sample_data, thresh_hi, thresh_lo, clear,
        input  shock_flags, shock_any, shock_chan, event_pulse, event_count
    );

    modport slave (
        input  sample_valid, sample_data, thresh_hi, thresh_lo, clear,
        output shock_flags, shock_any, shock_chan, event_pulse, event_count
    );
endinterface

// File: rtl/entropy_shock_channel.sv
// One entropy channel: EMA baseline, confirm/hold counters and the shock FSM.
// entering_o is the combinational strobe of the edge that moves the channel into SHOCK.
module entropy_shock_channel
    import entropy_shock_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned AVG_SHIFT = 3,
    parameter int unsigned CONFIRM   = 2,
    parameter int unsigned HOLD      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_valid_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] sample_i,
    input  logic [WIDTH-1:0] thresh_hi_i,
    input  logic [WIDTH-1:0] thresh_lo_i,
    output logic             flag_o,
    output logic             enter_o,
    output logic             entering_o
);
    localparam int unsigned     CntW       = $clog2(CONFIRM + 1);
    localparam int unsigned     HoldW      = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [CntW:0]   ConfirmVal = (CntW + 1)'(CONFIRM);
    localparam logic [HoldW-1:0] HoldInit  = HoldW'(HOLD - 1);

    shock_state_e      state_q;
    logic [WIDTH-1:0]  base_q;
    logic [CntW-1:0]   cnt_q;
    logic [HoldW-1:0]  hold_q;
    logic              flag_q;
    logic              enter_q;

    logic [MaxWidth:0]   delta;
    logic                over_hi;
    logic                over_lo;
    logic signed [WIDTH:0] diff;
    logic signed [WIDTH:0] step;
    logic signed [WIDTH:0] sum;
    logic [WIDTH-1:0]    ema;
    logic [CntW:0]       cnt_inc;
    logic                entering;

    always_comb begin
        delta    = abs_diff(MaxWidth'(sample_i), MaxWidth'(base_q));
        over_hi  = delta > (MaxWidth + 1)'(thresh_hi_i);
        over_lo  = delta > (MaxWidth + 1)'(thresh_lo_i);
        // Step lies between 0 and the full difference, so the sum stays in range.
        diff     = $signed({1'b0, sample_i}) - $signed({1'b0, base_q});
        step     = diff >>> AVG_SHIFT;
        sum      = $signed({1'b0, base_q}) + step;
        ema      = WIDTH'(sum);
        cnt_inc  = {1'b0, cnt_q} + (CntW + 1)'(1);
        entering = sample_valid_i && !clear_i && over_hi &&
                   (((state_q == StArmed) && (CONFIRM == 1)) ||
                    ((state_q == StPending) && (cnt_inc >= ConfirmVal)));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StPrime;
            base_q  <= '0;
            cnt_q   <= '0;
            hold_q  <= '0;
            flag_q  <= 1'b0;
            enter_q <= 1'b0;
        end else if (clear_i) begin
            state_q <= StPrime;
            base_q  <= '0;
            cnt_q   <= '0;
            hold_q  <= '0;
            flag_q  <= 1'b0;
            enter_q <= 1'b0;
        end else begin
            enter_q <= entering;
            if (entering) begin
                state_q <= StShock;
                flag_q  <= 1'b1;
                hold_q  <= HoldInit;
                cnt_q   <= '0;
            end else if (sample_valid_i) begin
                unique case (state_q)
                    StPrime: begin
                        base_q  <= sample_i;
                        state_q <= StArmed;
                    end
                    StArmed: begin
                        if (over_hi) begin
                            cnt_q   <= CntW'(1);
                            state_q <= StPending;
                        end else begin
                            base_q <= ema;
                        end
                    end
                    StPending: begin
                        if (over_hi) begin
                            cnt_q <= CntW'(cnt_inc);
                        end else begin
                            cnt_q   <= '0;
                            base_q  <= ema;
                            state_q <= StArmed;
                        end
                    end
                    StShock: begin
                        if (hold_q != '0) begin
                            hold_q <= hold_q - HoldW'(1);
                        end else if (!over_lo) begin
                            flag_q  <= 1'b0;
                            base_q  <= ema;
                            state_q <= StArmed;
                        end
                    end
                endcase
            end
        end
    end

    assign flag_o     = flag_q;
    assign enter_o    = enter_q;
    assign entering_o = entering;

endmodule

// File: rtl/entropy_shock_monitor.sv
// Multi-channel shock monitor: per-channel detectors plus flag summary and event counter.
// The counter advances on the same edge that raises the flags it counts.
module entropy_shock_monitor
    import entropy_shock_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned AVG_SHIFT = 3,
    parameter int unsigned CONFIRM   = 2,
    parameter int unsigned HOLD      = 16,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    entropy_shock_monitor_if.slave bus
);
    localparam int unsigned ChanW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned PopW  = $clog2(CHANNELS + 1);
    localparam int unsigned SumW  = ((CNT_W > PopW) ? CNT_W : PopW) + 1;

    logic [CHANNELS-1:0] flag;
    logic [CHANNELS-1:0] enter;
    logic [CHANNELS-1:0] entering;
    logic [PopW-1:0]     num_enter;
    logic [ChanW-1:0]    chan;
    logic [SumW-1:0]     sum;
    logic [CNT_W-1:0]    count_d;
    logic [CNT_W-1:0]    count_q;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        entropy_shock_channel #(
            .WIDTH    (WIDTH),
            .AVG_SHIFT(AVG_SHIFT),
            .CONFIRM  (CONFIRM),
            .HOLD     (HOLD)
        ) u_chan (
            .clk           (clk),
            .reset         (reset),
            .sample_valid_i(bus.sample_valid),
            .clear_i       (bus.clear),
            .sample_i      (bus.sample_data[c*WIDTH +: WIDTH]),
            .thresh_hi_i   (bus.thresh_hi),
            .thresh_lo_i   (bus.thresh_lo),
            .flag_o        (flag[c]),
            .enter_o       (enter[c]),
            .entering_o    (entering[c])
        );
    end

    always_comb begin
        num_enter = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            num_enter = num_enter + PopW'(entering[c]);
        end
        // Scan downwards so the lowest flagged index wins.
        chan = '0;
        for (int c = CHANNELS - 1; c >= 0; c--) begin
            if (flag[c]) chan = ChanW'(c);
        end
        sum     = SumW'(count_q) + SumW'(num_enter);
        count_d = (sum > SumW'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : CNT_W'(sum);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (bus.clear) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bus.shock_flags = flag;
    assign bus.shock_any   = |flag;
    assign bus.shock_chan  = chan;
    assign bus.event_pulse = |enter;
    assign bus.event_count = count_q;

endmodule

// File: tb/tb_entropy_shock_monitor.sv
// Scoreboard bench for entropy_shock_monitor: directed samples push expected results,
// a monitor pops and compares them after each registering edge.
module tb_entropy_shock_monitor;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    entropy_shock_monitor_if #(.WIDTH(8), .CHANNELS(4), .CNT_W(16)) bus ();
    entropy_shock_monitor_if #(.WIDTH(8), .CHANNELS(4), .CNT_W(2))  bus2 ();

    entropy_shock_monitor #(
        .WIDTH(8), .CHANNELS(4), .AVG_SHIFT(3), .CONFIRM(2), .HOLD(4), .CNT_W(16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    entropy_shock_monitor #(
        .WIDTH(8), .CHANNELS(4), .AVG_SHIFT(3), .CONFIRM(2), .HOLD(4), .CNT_W(2)
    ) dut_sat (
        .clk  (clk),
        .reset(reset),
        .bus  (bus2)
    );

    typedef struct {
        logic [3:0]  flags;
        logic        pulse;
        logic [15:0] count;
        logic [1:0]  count2;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   ecount = 0;
    int   ecount2 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [1:0] low_idx(input logic [3:0] f);
        logic [1:0] r = 2'd0;
        for (int i = 3; i >= 0; i--) if (f[i]) r = i[1:0];
        return r;
    endfunction

    // One stimulus cycle plus the expected state after its registering edge.
    task automatic drive(input bit v, input bit c, input logic [7:0] s0, input logic [7:0] s1,
                         input logic [7:0] s2, input logic [7:0] s3,
                         input logic [3:0] ef, input int en);
        exp_t e;
        @(posedge clk);
        #1;
        bus.sample_valid  = v;
        bus.clear         = c;
        bus.sample_data   = {s3, s2, s1, s0};
        bus2.sample_valid = v;
        bus2.clear        = c;
        bus2.sample_data  = {s3, s2, s1, s0};
        if (c) begin
            ecount  = 0;
            ecount2 = 0;
        end else begin
            ecount  = ecount + en;
            ecount2 = (ecount2 + en > 3) ? 3 : ecount2 + en;
        end
        e.flags  = ef;
        e.pulse  = (en != 0);
        e.count  = 16'(ecount);
        e.count2 = 2'(ecount2);
        exp_q.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_flags"}, 32'(bus.shock_flags), 32'd0);
        chk({tag, "_any"},   32'(bus.shock_any),   32'd0);
        chk({tag, "_chan"},  32'(bus.shock_chan),  32'd0);
        chk({tag, "_pulse"}, 32'(bus.event_pulse), 32'd0);
        chk({tag, "_count"}, 32'(bus.event_count), 32'd0);
        chk({tag, "_count2"}, 32'(bus2.event_count), 32'd0);
    endtask

    // Monitor: an entry queued before an edge is compared at the following negedge.
    initial begin
        bit   due;
        exp_t e;
        forever begin
            @(posedge clk);
            due = (exp_q.size() > 0);
            @(negedge clk);
            if (due) begin
                e = exp_q.pop_front();
                chk("flags",  32'(bus.shock_flags),  32'(e.flags));
                chk("any",    32'(bus.shock_any),    32'(|e.flags));
                chk("chan",   32'(bus.shock_chan),   32'(low_idx(e.flags)));
                chk("pulse",  32'(bus.event_pulse),  32'(e.pulse));
                chk("count",  32'(bus.event_count),  32'(e.count));
                chk("count_sat", 32'(bus2.event_count), 32'(e.count2));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        bus.sample_valid  = 1'b0;
        bus.clear         = 1'b0;
        bus.sample_data   = {4{8'd100}};
        bus.thresh_hi     = 8'd20;
        bus.thresh_lo     = 8'd8;
        bus2.sample_valid = 1'b0;
        bus2.clear        = 1'b0;
        bus2.sample_data  = {4{8'd100}};
        bus2.thresh_hi    = 8'd20;
        bus2.thresh_lo    = 8'd8;
        #12;
        chk_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        // Single spike must not assert.
        repeat (10) drive(1, 0, 100, 100, 100, 100, 4'b0000, 0);
        drive(1, 0, 130, 100, 100, 100, 4'b0000, 0);
        repeat (3) drive(1, 0, 100, 100, 100, 100, 4'b0000, 0);

        // Two consecutive spikes assert on the second.
        drive(1, 0, 130, 100, 100, 100, 4'b0000, 0);
        drive(1, 0, 130, 100, 100, 100, 4'b0001, 1);

        // Hold of 4, hysteresis at thresh_lo.
        repeat (3) drive(1, 0, 100, 100, 100, 100, 4'b0001, 0);
        repeat (2) drive(1, 0, 110, 100, 100, 100, 4'b0001, 0);
        drive(1, 0, 100, 100, 100, 100, 4'b0000, 0);
        drive(1, 0, 100, 100, 100, 100, 4'b0000, 0);

        // ch1 and ch3 enter together.
        drive(1, 0, 100, 150, 100, 150, 4'b0000, 0);
        drive(1, 0, 100, 150, 100, 150, 4'b1010, 2);
        repeat (3) drive(1, 0, 100, 100, 100, 100, 4'b1010, 0);
        drive(1, 0, 100, 100, 100, 100, 4'b0000, 0);

        // Gapped valid: invalid cycles carry junk and must be ignored.
        drive(1, 0, 130, 100, 100, 100, 4'b0000, 0);
        repeat (2) drive(0, 0, 0, 0, 0, 0, 4'b0000, 0);
        drive(1, 0, 130, 100, 100, 100, 4'b0001, 1);
        repeat (2) drive(0, 0, 0, 0, 0, 0, 4'b0001, 0);
        repeat (3) begin
            drive(1, 0, 100, 100, 100, 100, 4'b0001, 0);
            repeat (2) drive(0, 0, 0, 0, 0, 0, 4'b0001, 0);
        end
        drive(1, 0, 100, 100, 100, 100, 4'b0000, 0);
        drive(0, 0, 0, 0, 0, 0, 4'b0000, 0);

        // Clear while ch2 pending, then re-prime.
        drive(1, 0, 100, 100, 150, 100, 4'b0000, 0);
        drive(1, 1, 100, 100, 150, 100, 4'b0000, 0);
        drive(1, 0, 100, 100, 150, 100, 4'b0000, 0);
        drive(1, 0, 100, 100, 150, 100, 4'b0000, 0);
        drive(1, 0, 100, 100, 100, 100, 4'b0000, 0);
        drive(1, 0, 100, 100, 100, 100, 4'b0100, 1);
        // Clear while ch2 in SHOCK.
        drive(0, 1, 100, 100, 100, 100, 4'b0000, 0);
        drive(1, 0, 100, 100, 100, 100, 4'b0000, 0);
        drive(1, 0, 100, 100, 100, 100, 4'b0000, 0);

        // Drive ch2 into SHOCK, then asynchronous reset mid-cycle.
        drive(1, 0, 100, 100, 130, 100, 4'b0000, 0);
        drive(1, 0, 100, 100, 130, 100, 4'b0100, 1);
        drive(0, 0, 100, 100, 130, 100, 4'b0100, 0);
        drain();
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk_zero("async_rst");
        ecount  = 0;
        ecount2 = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // First sample after reset only primes.
        drive(1, 0, 100, 100, 130, 100, 4'b0000, 0);
        drive(1, 0, 100, 100, 130, 100, 4'b0000, 0);
        drive(1, 0, 100, 100, 130, 100, 4'b0000, 0);
        drive(0, 0, 0, 0, 0, 0, 4'b0000, 0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
